// File: rtl/bcd_serial_add_ctrl.sv
// rtl/bcd_serial_add_ctrl.sv - digit-serial packed-BCD adder sequencer driving a shared one-digit BCD adder
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] op_a,
    input  logic [4*DIGITS-1:0] op_b,
    input  logic                cin,
    output logic [3:0]          dig_a,
    output logic [3:0]          dig_b,
    output logic                dig_ci,
    input  logic [3:0]          dig_sum,
    input  logic                dig_co,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] result,
    output logic                cout,
    output logic                invalid
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          carry_q, carry_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  result_q, result_d;
    logic          cout_q, cout_d;
    logic          invalid_q, invalid_d;
    logic          bad_digit;

    // Flag any non-decimal digit in the operands offered at acceptance
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (op_a[4*i +: 4] > 4'd9 || op_b[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    // Next-state logic: accept in IDLE, one digit per cycle in RUN, single DONE cycle
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        result_d  = result_q;
        cout_d    = cout_q;
        invalid_d = invalid_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d       = op_a;
                    b_d       = op_b;
                    carry_d   = cin;
                    idx_d     = '0;
                    result_d  = '0;
                    cout_d    = 1'b0;
                    invalid_d = bad_digit;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                result_d[{idx_q, 2'b00} +: 4] = dig_sum;
                carry_d = dig_co;
                if (idx_q == LAST_IDX) begin
                    cout_d  = dig_co;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            carry_q   <= carry_d;
            idx_q     <= idx_d;
            result_q  <= result_d;
            cout_q    <= cout_d;
            invalid_q <= invalid_d;
        end
    end

    // Adder operands come straight from registers so they are stable the whole RUN cycle
    assign dig_a   = (state_q == S_RUN) ? a_q[{idx_q, 2'b00} +: 4] : 4'd0;
    assign dig_b   = (state_q == S_RUN) ? b_q[{idx_q, 2'b00} +: 4] : 4'd0;
    assign dig_ci  = (state_q == S_RUN) ? carry_q : 1'b0;
    assign busy    = (state_q == S_RUN) || (state_q == S_DONE);
    assign done    = (state_q == S_DONE);
    assign result  = result_q;
    assign cout    = cout_q;
    assign invalid = invalid_q;

endmodule
